// File: rtl/risc_control_unit_if.sv
// rtl/risc_control_unit_if.sv - control bus between the RISC sequencer and its datapath
//
// Purpose: groups the instruction/flag inputs and every datapath select and
// strobe driven by risc_control_unit.
// Ports (modport master = control unit, slave = datapath):
//   instruction [7:0]  current IR contents (opcode [7:4], src [3:2], dest [1:0])
//   zero               registered ALU zero flag
//   alu_sel [3:0]      ALU opcode select
//   load_r [3:0]       one-hot register load R0..R3
//   sel_bus_1 [2:0]    Bus_1 source (0..3 = R0..R3, 4 = PC)
//   sel_bus_2 [1:0]    Bus_2 source (0 = ALU, 1 = Bus_1, 2 = memory)
//   load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write
//                      datapath strobes
//   halted, illegal    HALT status
interface risc_control_unit_if;
  logic [7:0] instruction;
  logic       zero;
  logic [3:0] alu_sel;
  logic [3:0] load_r;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;
  logic       load_pc;
  logic       inc_pc;
  logic       load_ir;
  logic       load_add_r;
  logic       load_reg_y;
  logic       load_reg_z;
  logic       write;
  logic       halted;
  logic       illegal;

  modport master (
    input  instruction, zero,
    output alu_sel, load_r, sel_bus_1, sel_bus_2, load_pc, inc_pc, load_ir,
           load_add_r, load_reg_y, load_reg_z, write, halted, illegal
  );

  modport slave (
    output instruction, zero,
    input  alu_sel, load_r, sel_bus_1, sel_bus_2, load_pc, inc_pc, load_ir,
           load_add_r, load_reg_y, load_reg_z, write, halted, illegal
  );
endinterface

// File: rtl/risc_control_unit.sv
// rtl/risc_control_unit.sv - Moore sequencer for the 8-bit stored-program RISC core
//
// Purpose: fetches, decodes and executes one instruction at a time. Only the
// state is registered; every output decodes from the state and the IR.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (forces IDLE, all outputs 0)
//   bus   risc_control_unit_if.master: instruction/zero in, selects/strobes out
// Configuration macro: RISC_ILLEGAL_HALT_EN
//   defined   -> opcodes 12..15 halt the core with illegal=1 (exit by reset only)
//   undefined -> opcodes 12..15 execute as NOP and illegal is tied 0
module risc_control_unit (
  input  logic                 clk,
  input  logic                 rst,
  risc_control_unit_if.master  bus
);

  localparam int word_size = 8;
  localparam int op_size   = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_INC = 4'd11;

  localparam logic [2:0] B1_PC  = 3'd4;
  localparam logic [1:0] B2_ALU = 2'd0;
  localparam logic [1:0] B2_B1  = 2'd1;
  localparam logic [1:0] B2_MEM = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2,
    S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [op_size-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;

  assign opcode = bus.instruction[word_size-1 -: op_size];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.alu_sel    = OP_NOP;
    bus.load_r     = 4'b0000;
    bus.sel_bus_1  = 3'd0;
    bus.sel_bus_2  = B2_ALU;
    bus.load_pc    = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.load_ir    = 1'b0;
    bus.load_add_r = 1'b0;
    bus.load_reg_y = 1'b0;
    bus.load_reg_z = 1'b0;
    bus.write      = 1'b0;
    bus.halted     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        bus.sel_bus_1  = B1_PC;
        bus.sel_bus_2  = B2_B1;
        bus.load_add_r = 1'b1;
        state_d        = S_FET2;
      end
      S_FET2: begin
        bus.sel_bus_2 = B2_MEM;
        bus.load_ir   = 1'b1;
        bus.inc_pc    = 1'b1;
        state_d       = S_DEC;
      end
      S_DEC: begin
        state_d = S_FET1;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND: begin
            // Latch src into Reg_Y; the ALU op runs next cycle with dest on Bus_1.
            bus.sel_bus_1  = {1'b0, src};
            bus.sel_bus_2  = B2_B1;
            bus.load_reg_y = 1'b1;
            state_d        = S_EX1;
          end
          OP_NOT, OP_SHL, OP_SHR, OP_INC: begin
            bus.sel_bus_1  = {1'b0, src};
            bus.alu_sel    = opcode;
            bus.sel_bus_2  = B2_ALU;
            bus.load_reg_z = 1'b1;
            bus.load_r     = 4'b0001 << dest;
          end
          OP_RD, OP_WR, OP_BR: begin
            bus.sel_bus_1  = B1_PC;
            bus.sel_bus_2  = B2_B1;
            bus.load_add_r = 1'b1;
            state_d        = (opcode == OP_RD) ? S_RD1 :
                             (opcode == OP_WR) ? S_WR1 : S_BR1;
          end
          OP_BRZ: begin
            if (bus.zero) begin
              bus.sel_bus_1  = B1_PC;
              bus.sel_bus_2  = B2_B1;
              bus.load_add_r = 1'b1;
              state_d        = S_BR1;
            end else begin
              // Not taken: step the PC past the branch target byte.
              bus.inc_pc = 1'b1;
            end
          end
          default: begin
`ifdef RISC_ILLEGAL_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_FET1;
`endif
          end
        endcase
      end
      S_EX1: begin
        bus.sel_bus_1  = {1'b0, dest};
        bus.alu_sel    = opcode;
        bus.sel_bus_2  = B2_ALU;
        bus.load_reg_z = 1'b1;
        bus.load_r     = 4'b0001 << dest;
        state_d        = S_FET1;
      end
      S_RD1, S_WR1, S_BR1: begin
        // Operand byte is the target address; RD/WR then skip past it.
        bus.sel_bus_2  = B2_MEM;
        bus.load_add_r = 1'b1;
        bus.inc_pc     = (state_q != S_BR1);
        state_d        = (state_q == S_RD1) ? S_RD2 :
                         (state_q == S_WR1) ? S_WR2 : S_BR2;
      end
      S_RD2: begin
        bus.sel_bus_2 = B2_MEM;
        bus.load_r    = 4'b0001 << dest;
        state_d       = S_FET1;
      end
      S_WR2: begin
        bus.sel_bus_1 = {1'b0, src};
        bus.write     = 1'b1;
        state_d       = S_FET1;
      end
      S_BR2: begin
        bus.sel_bus_2 = B2_MEM;
        bus.load_pc   = 1'b1;
        state_d       = S_FET1;
      end
      S_HALT: begin
        bus.halted = 1'b1;
        state_d    = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RISC_ILLEGAL_HALT_EN
  // HALT is only reachable through an illegal opcode.
  assign bus.illegal = (state_q == S_HALT);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_risc_control_unit.sv
// tb/tb_risc_control_unit.sv - directed self-checking bench for risc_control_unit
module tb_risc_control_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  risc_control_unit_if bus_if ();

  risc_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe field order: {load_pc, inc_pc, load_ir, load_add_r, load_reg_y,
  //                      load_reg_z, write, halted, illegal}
  localparam logic [8:0] T_PC  = 9'b100000000;
  localparam logic [8:0] T_INC = 9'b010000000;
  localparam logic [8:0] T_IR  = 9'b001000000;
  localparam logic [8:0] T_ADR = 9'b000100000;
  localparam logic [8:0] T_Y   = 9'b000010000;
  localparam logic [8:0] T_Z   = 9'b000001000;
  localparam logic [8:0] T_WR  = 9'b000000100;
  localparam logic [8:0] T_H   = 9'b000000010;
  localparam logic [8:0] T_IL  = 9'b000000001;

  function automatic logic [21:0] mk(input logic [3:0] alu, input logic [3:0] lr,
                                     input logic [2:0] b1, input logic [1:0] b2,
                                     input logic [8:0] st);
    return {alu, lr, b1, b2, st};
  endfunction

  function automatic logic [21:0] obs();
    return {bus_if.alu_sel, bus_if.load_r, bus_if.sel_bus_1, bus_if.sel_bus_2,
            bus_if.load_pc, bus_if.inc_pc, bus_if.load_ir, bus_if.load_add_r,
            bus_if.load_reg_y, bus_if.load_reg_z, bus_if.write,
            bus_if.halted, bus_if.illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("onehot_load_r", 32'($countones(bus_if.load_r) <= 1), 32'd1);
    check("write_vs_load_r", 32'(bus_if.write && (bus_if.load_r != 4'b0)), 32'd0);
  endtask

  // Entered in FET1; leaves the bench in DEC of the new instruction.
  task automatic fetch(input string t, input logic [7:0] ir, input logic z);
    check({t, "_fet1"}, 32'(obs()), 32'(mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR)));
    bus_if.instruction = ir;
    bus_if.zero        = z;
    step();
    check({t, "_fet2"}, 32'(obs()), 32'(mk(4'd0, 4'd0, 3'd0, 2'd2, T_IR | T_INC)));
    step();
  endtask

  task automatic expect_state(input string t, input logic [21:0] e);
    check(t, 32'(obs()), 32'(e));
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    bus_if.instruction = 8'h00;
    bus_if.zero = 1'b0;

    #3;
    check("reset_outputs", 32'(obs()), 32'd0);
    @(posedge clk); #1;
    check("reset_held", 32'(obs()), 32'd0);
    #2 rst = 1'b1;
    #1 check("idle_after_release", 32'(obs()), 32'd0);
    step();

    fetch("nop", 8'h00, 1'b0);
    expect_state("nop_dec", mk(4'd0, 4'd0, 3'd0, 2'd0, 9'd0));

    fetch("add", 8'h16, 1'b0);
    expect_state("add_dec", mk(4'd0, 4'd0, 3'd1, 2'd1, T_Y));
    expect_state("add_ex1", mk(4'd1, 4'b0100, 3'd2, 2'd0, T_Z));

    fetch("sub", 8'h2B, 1'b0);
    expect_state("sub_dec", mk(4'd0, 4'd0, 3'd2, 2'd1, T_Y));
    expect_state("sub_ex1", mk(4'd2, 4'b1000, 3'd3, 2'd0, T_Z));

    fetch("and", 8'h3E, 1'b0);
    expect_state("and_dec", mk(4'd0, 4'd0, 3'd3, 2'd1, T_Y));
    expect_state("and_ex1", mk(4'd3, 4'b0100, 3'd2, 2'd0, T_Z));

    fetch("shl", 8'h9C, 1'b0);
    expect_state("shl_dec", mk(4'd9, 4'b0001, 3'd3, 2'd0, T_Z));

    fetch("not", 8'h41, 1'b0);
    expect_state("not_dec", mk(4'd4, 4'b0010, 3'd0, 2'd0, T_Z));

    fetch("shr", 8'hA6, 1'b0);
    expect_state("shr_dec", mk(4'd10, 4'b0100, 3'd1, 2'd0, T_Z));

    fetch("inc", 8'hB7, 1'b0);
    expect_state("inc_dec", mk(4'd11, 4'b1000, 3'd1, 2'd0, T_Z));

    fetch("brz_nt", 8'h80, 1'b0);
    expect_state("brz_nt_dec", mk(4'd0, 4'd0, 3'd0, 2'd0, T_INC));

    fetch("brz_t", 8'h80, 1'b1);
    expect_state("brz_t_dec", mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR));
    expect_state("brz_t_br1", mk(4'd0, 4'd0, 3'd0, 2'd2, T_ADR));
    expect_state("brz_t_br2", mk(4'd0, 4'd0, 3'd0, 2'd2, T_PC));

    fetch("br", 8'h70, 1'b0);
    expect_state("br_dec", mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR));
    expect_state("br_br1", mk(4'd0, 4'd0, 3'd0, 2'd2, T_ADR));
    expect_state("br_br2", mk(4'd0, 4'd0, 3'd0, 2'd2, T_PC));

    fetch("rd", 8'h52, 1'b0);
    expect_state("rd_dec", mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR));
    expect_state("rd_rd1", mk(4'd0, 4'd0, 3'd0, 2'd2, T_ADR | T_INC));
    expect_state("rd_rd2", mk(4'd0, 4'b0100, 3'd0, 2'd2, 9'd0));

    fetch("wr", 8'h63, 1'b0);
    expect_state("wr_dec", mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR));
    expect_state("wr_wr1", mk(4'd0, 4'd0, 3'd0, 2'd2, T_ADR | T_INC));
    expect_state("wr_wr2", mk(4'd0, 4'd0, 3'd0, 2'd0, T_WR));

    // Reset pulse in the middle of EX1.
    fetch("rst_add", 8'h16, 1'b0);
    expect_state("rst_add_dec", mk(4'd0, 4'd0, 3'd1, 2'd1, T_Y));
    check("rst_add_ex1", 32'(obs()), 32'(mk(4'd1, 4'b0100, 3'd2, 2'd0, T_Z)));
    #2 rst = 1'b0;
    #1 check("rst_mid_ex1", 32'(obs()), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_held", 32'(obs()), 32'd0);
    #2 rst = 1'b1;
    #1 check("rst_mid_idle", 32'(obs()), 32'd0);
    step();

    fetch("ill", 8'hF0, 1'b0);
    expect_state("ill_dec", mk(4'd0, 4'd0, 3'd0, 2'd0, 9'd0));
`ifdef RISC_ILLEGAL_HALT_EN
    for (int i = 0; i < 20; i++) begin
      expect_state("ill_halt", mk(4'd0, 4'd0, 3'd0, 2'd0, T_H | T_IL));
    end
    rst = 1'b0;
    #1 check("halt_reset", 32'(obs()), 32'd0);
    #2 rst = 1'b1;
    step();
`endif
    fetch("post", 8'h00, 1'b0);
    expect_state("post_dec", mk(4'd0, 4'd0, 3'd0, 2'd0, 9'd0));
    check("post_fet1", 32'(obs()), 32'(mk(4'd0, 4'd0, 3'd4, 2'd1, T_ADR)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
